// File: rtl/ep_rst_seq_pkg.sv
// Shared types and constants for the PCIe endpoint staged reset-release sequencer.
package ep_rst_seq_pkg;

    localparam int STAGE_DLY_DEF   = 16;
    localparam int QUIESCE_TMO_DEF = 1024;
    localparam int DROP_CNT_MAX    = 255;

    typedef enum logic [5:0] {
        ST_HOLD    = 6'b000001,
        ST_REL_RX  = 6'b000010,
        ST_REL_TX  = 6'b000100,
        ST_REL_IRQ = 6'b001000,
        ST_RUN     = 6'b010000,
        ST_QUIESCE = 6'b100000
    } state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'(DROP_CNT_MAX)) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ep_rst_seq_dly.sv
// Loadable stage-gap up-counter; tc pulses while enabled at count STAGE_DLY-1.
module ep_rst_seq_dly #(
    parameter int STAGE_DLY = 16,
    parameter int CNT_W     = 5
) (
    input  logic             clk250,
    input  logic             reset250_n,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk250 or negedge reset250_n) begin
        if (!reset250_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign tc = en && (cnt == CNT_W'(STAGE_DLY - 1));

endmodule

// File: rtl/ep_rst_seq.sv
// Staged reset release (rx DMA -> tx DMA -> irq) with quiesce handshake on link drop.
// EP_RST_SEQ_TMO_EN adds a quiesce timeout and the sticky tmo_flag.
//
// state      | meaning
// HOLD       | all resets asserted, waiting for rst250 low
// REL_RX     | gap before rx DMA release
// REL_TX     | gap before tx DMA release
// REL_IRQ    | gap before interrupt release and sys_ready
// RUN        | everything released
// QUIESCE    | link dropped, waiting for DMA idle acknowledge
module ep_rst_seq
    import ep_rst_seq_pkg::*;
#(
    parameter int STAGE_DLY   = STAGE_DLY_DEF,
    parameter int CNT_W       = 5,
    parameter int QUIESCE_TMO = QUIESCE_TMO_DEF,
    parameter int TMO_W       = 11
) (
    input  logic       clk250,
    input  logic       reset250_n,
    input  logic       rst250,
    input  logic       quiesce_ack,
    output logic       rx_rst,
    output logic       tx_rst,
    output logic       irq_rst,
    output logic       quiesce_req,
    output logic       sys_ready,
    output logic [7:0] drop_cnt,
    output logic       tmo_flag
);

    state_t     state, state_nxt;
    logic       rx_nxt, tx_nxt, irq_nxt, req_nxt, rdy_nxt;
    logic [7:0] drop_nxt;
    logic       stage_en, stage_clr, stage_tc;
    logic       tmo_hit;

    ep_rst_seq_dly #(.STAGE_DLY(STAGE_DLY), .CNT_W(CNT_W)) u_dly (
        .clk250     (clk250),
        .reset250_n (reset250_n),
        .clr        (stage_clr),
        .load       (1'b0),
        .load_val   ({CNT_W{1'b0}}),
        .en         (stage_en),
        .tc         (stage_tc)
    );

`ifdef EP_RST_SEQ_TMO_EN
    logic [TMO_W-1:0] tmo_cnt;

    assign tmo_hit = (state == ST_QUIESCE) && (tmo_cnt == TMO_W'(QUIESCE_TMO - 1));

    always_ff @(posedge clk250 or negedge reset250_n) begin
        if (!reset250_n) begin
            tmo_cnt  <= '0;
            tmo_flag <= 1'b0;
        end else begin
            tmo_cnt <= (state == ST_QUIESCE) ? tmo_cnt + 1'b1 : '0;
            // a real ack in the same cycle is not a timeout
            if (tmo_hit && !quiesce_ack)
                tmo_flag <= 1'b1;
        end
    end
`else
    assign tmo_hit  = 1'b0;
    assign tmo_flag = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        rx_nxt    = rx_rst;
        tx_nxt    = tx_rst;
        irq_nxt   = irq_rst;
        req_nxt   = quiesce_req;
        rdy_nxt   = sys_ready;
        drop_nxt  = drop_cnt;
        stage_en  = 1'b0;
        stage_clr = 1'b1;
        case (state)
            ST_HOLD: begin
                {rx_nxt, tx_nxt, irq_nxt} = 3'b111;
                req_nxt = 1'b0;
                rdy_nxt = 1'b0;
                if (!rst250)
                    state_nxt = ST_REL_RX;
            end
            ST_REL_RX, ST_REL_TX, ST_REL_IRQ: begin
                stage_en  = 1'b1;
                stage_clr = stage_tc || rst250;
                if (rst250) begin
                    {rx_nxt, tx_nxt, irq_nxt} = 3'b111;
                    rdy_nxt   = 1'b0;
                    state_nxt = ST_HOLD;
                end else if (stage_tc) begin
                    if (state == ST_REL_RX) begin
                        rx_nxt    = 1'b0;
                        state_nxt = ST_REL_TX;
                    end else if (state == ST_REL_TX) begin
                        tx_nxt    = 1'b0;
                        state_nxt = ST_REL_IRQ;
                    end else begin
                        irq_nxt   = 1'b0;
                        rdy_nxt   = 1'b1;
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (rst250) begin
                    rdy_nxt   = 1'b0;
                    req_nxt   = 1'b1;
                    drop_nxt  = sat_inc(drop_cnt);
                    state_nxt = ST_QUIESCE;
                end
            end
            ST_QUIESCE: begin
                if (quiesce_ack || tmo_hit) begin
                    req_nxt   = 1'b0;
                    {rx_nxt, tx_nxt, irq_nxt} = 3'b111;
                    state_nxt = ST_HOLD;
                end
            end
            default: begin
                {rx_nxt, tx_nxt, irq_nxt} = 3'b111;
                req_nxt   = 1'b0;
                rdy_nxt   = 1'b0;
                state_nxt = ST_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk250 or negedge reset250_n) begin
        if (!reset250_n) begin
            state       <= ST_HOLD;
            rx_rst      <= 1'b1;
            tx_rst      <= 1'b1;
            irq_rst     <= 1'b1;
            quiesce_req <= 1'b0;
            sys_ready   <= 1'b0;
            drop_cnt    <= 8'd0;
        end else begin
            state       <= state_nxt;
            rx_rst      <= rx_nxt;
            tx_rst      <= tx_nxt;
            irq_rst     <= irq_nxt;
            quiesce_req <= req_nxt;
            sys_ready   <= rdy_nxt;
            drop_cnt    <= drop_nxt;
        end
    end

endmodule
